// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply datapath blocks:
//   - default element / accumulator widths
//   - input-side FSM state encoding used by dot_product_mac
//   - saturation helpers used to clamp a wide accumulator to DATA_W bits
// No ports (package).
// ---------------------------------------------------------------------------
package mm_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;

    // Width of the helper arithmetic below; accumulators up to this wide and
    // output widths strictly below it are handled.
    localparam int SAT_MAX_W  = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no dot product open
        ST_ACC  = 1'b1    // first beat accepted, last beat not yet seen
    } in_state_e;

    // Largest unsigned value representable in out_w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int out_w);
        return (SAT_MAX_W'(1) << out_w) - SAT_MAX_W'(1);
    endfunction

    // True when val does not fit in out_w unsigned bits, i.e. the value
    // must be clamped to sat_max(out_w).
    function automatic logic sat_over(input logic [SAT_MAX_W-1:0] val,
                                      input int                   out_w);
        return (val > sat_max(out_w));
    endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// ---------------------------------------------------------------------------
// dot_product_mac_if
// Beat/result bundle of dot_product_mac.
//   master : producer of a/b beats and consumer of results (drives a*, b*,
//            in_valid, in_last, beats)
//   slave  : the MAC itself (drives result, ovf, out_valid, err, busy)
// ---------------------------------------------------------------------------
interface dot_product_mac_if #(
    parameter int DATA_W = mm_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] a1, a2, a3, a4;
    logic [DATA_W-1:0] b1, b2, b3, b4;
    logic              in_valid;
    logic              in_last;
    logic [7:0]        beats;

    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              out_valid;
    logic              err;
    logic              busy;

    modport master (
        output a1, a2, a3, a4, b1, b2, b3, b4, in_valid, in_last, beats,
        input  result, ovf, out_valid, err, busy
    );

    modport slave (
        input  a1, a2, a3, a4, b1, b2, b3, b4, in_valid, in_last, beats,
        output result, ovf, out_valid, err, busy
    );
endinterface

// File: rtl/dp_sum4.sv
// ---------------------------------------------------------------------------
// dp_sum4
// First two pipeline stages of the dot-product MAC.
//   S1: registers the four unsigned products a_i[k]*b_i[k] (2*DATA_W bits)
//   S2: registers their sum (2*DATA_W+2 bits, no precision lost)
// A valid bit and a generic flag vector travel alongside each beat.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a_i, b_i        four operand pairs, index 0 = element 1
//   valid_i,flags_i beat qualifier and sideband flags
//   sum_o           registered four-product sum (S2)
//   valid_o,flags_o S2 qualifier and flags
// ---------------------------------------------------------------------------
module dp_sum4 #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0][DATA_W-1:0]       a_i,
    input  logic [3:0][DATA_W-1:0]       b_i,
    input  logic                         valid_i,
    input  logic [FLAG_W-1:0]            flags_i,
    output logic [2*DATA_W+1:0]          sum_o,
    output logic                         valid_o,
    output logic [FLAG_W-1:0]            flags_o
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 2;

    logic [3:0][PROD_W-1:0] prod_w;
    logic [3:0][PROD_W-1:0] prod_q;
    logic                   s1_valid_q;
    logic [FLAG_W-1:0]      s1_flags_q;

    logic [SUM_W-1:0]       sum_q;
    logic                   s2_valid_q;
    logic [FLAG_W-1:0]      s2_flags_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mul
            assign prod_w[gi] = PROD_W'(a_i[gi]) * PROD_W'(b_i[gi]);
        end
    endgenerate

    // S1: product registers. Data only loads on a valid beat so idle cycles
    // leave the registers quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_flags_q <= '0;
        end else begin
            s1_valid_q <= valid_i;
            s1_flags_q <= valid_i ? flags_i : '0;
            if (valid_i) begin
                prod_q <= prod_w;
            end
        end
    end

    // S2: adder tree, widened so four full-scale products cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_flags_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_flags_q <= s1_flags_q;
            if (s1_valid_q) begin
                sum_q <= (SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]))
                       + (SUM_W'(prod_q[2]) + SUM_W'(prod_q[3]));
            end
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = s2_valid_q;
    assign flags_o = s2_flags_q;

endmodule

// File: rtl/dot_product_mac.sv
// ---------------------------------------------------------------------------
// dot_product_mac
// Streaming dot-product engine: accepts one beat of four A-row and four
// B-column elements per cycle, accumulates the beats of one dot product and
// emits the result clamped to DATA_W bits.
//   beat sampled at edge t (with in_last) -> out_valid high after edge t+3
// Pipeline: dp_sum4 (S1 products, S2 sum) -> S3 accumulator -> output regs.
// An input FSM tracks whether a dot product is open, counts its beats and
// flags a mismatch against the expected count sampled on the first beat.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       dot_product_mac_if.slave: a1..a4, b1..b4, in_valid, in_last,
//             beats in; result, ovf, out_valid, err, busy out
// ---------------------------------------------------------------------------
module dot_product_mac
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    dot_product_mac_if.slave bus
);
    localparam int SUM_W      = 2 * DATA_W + 2;
    localparam int FLAG_W     = 3;
    localparam int FLAG_FIRST = 0;
    localparam int FLAG_LAST  = 1;
    localparam int FLAG_ERR   = 2;

    // ---------------- input FSM and beat counter ----------------
    in_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  beats_q, beats_d;
    logic [7:0]  beat_cnt;
    logic [7:0]  exp_beats;
    logic        is_first;
    logic        beat_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        is_first  = (state_q == ST_IDLE);
        // Count this beat would carry if accepted; saturates at 255.
        beat_cnt  = 8'd1;
        if (!is_first) begin
            beat_cnt = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        end
        // The expected count comes straight from the port on a first beat
        // so single-beat dot products are checked too.
        exp_beats = is_first ? bus.beats : beats_q;
        // Only meaningful on the last beat; it rides down with the beat.
        beat_err  = (exp_beats != 8'd0) && (beat_cnt != exp_beats);
        if (bus.in_valid) begin
            cnt_d   = beat_cnt;
            beats_d = exp_beats;
            state_d = bus.in_last ? ST_IDLE : ST_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            beats_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
        end
    end

    assign bus.busy = (state_q == ST_ACC);

    // ---------------- S1/S2 ----------------
    logic [3:0][DATA_W-1:0] a_vec, b_vec;
    logic [FLAG_W-1:0]      in_flags;
    logic [SUM_W-1:0]       s2_sum;
    logic                   s2_valid;
    logic [FLAG_W-1:0]      s2_flags;

    assign a_vec = {bus.a4, bus.a3, bus.a2, bus.a1};
    assign b_vec = {bus.b4, bus.b3, bus.b2, bus.b1};

    always_comb begin
        in_flags             = '0;
        in_flags[FLAG_FIRST] = is_first;
        in_flags[FLAG_LAST]  = bus.in_last;
        in_flags[FLAG_ERR]   = beat_err;
    end

    dp_sum4 #(
        .DATA_W (DATA_W),
        .FLAG_W (FLAG_W)
    ) u_sum4 (
        .clk     (clk),
        .rst     (rst),
        .a_i     (a_vec),
        .b_i     (b_vec),
        .valid_i (bus.in_valid),
        .flags_i (in_flags),
        .sum_o   (s2_sum),
        .valid_o (s2_valid),
        .flags_o (s2_flags)
    );

    // ---------------- S3 accumulator ----------------
    logic [ACC_W-1:0] acc_q;
    logic             s3_done_q;   // acc_q holds a completed dot product
    logic             s3_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            s3_done_q <= 1'b0;
            s3_err_q  <= 1'b0;
        end else begin
            s3_done_q <= s2_valid & s2_flags[FLAG_LAST];
            s3_err_q  <= s2_valid & s2_flags[FLAG_LAST] & s2_flags[FLAG_ERR];
            if (s2_valid) begin
                // Modulo 2^ACC_W by construction of the register width.
                acc_q <= s2_flags[FLAG_FIRST] ? ACC_W'(s2_sum)
                                              : acc_q + ACC_W'(s2_sum);
            end
        end
    end

    // ---------------- output registers ----------------
    logic              acc_over;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;
    logic              out_valid_q;
    logic              err_q;

    assign acc_over = sat_over(SAT_MAX_W'(acc_q), DATA_W);

    // The next beat's first load into acc_q happens on the same edge the
    // output registers capture the previous total, so back-to-back dot
    // products need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= s3_done_q;
            err_q       <= s3_err_q;
            if (s3_done_q) begin
                result_q <= acc_over ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
                ovf_q    <= acc_over;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

endmodule

// File: doc/dot_product_mac.md
DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

Interface
REQ-001 Parameter DATA_W, default 16, width of each matrix element.
REQ-002 Parameter ACC_W, default 40, accumulator width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a1,a2,a3,a4  input  DATA_W each  four consecutive row elements of matrix A (from dataA q1..q4).
REQ-006 b1,b2,b3,b4  input  DATA_W each  four consecutive column elements of matrix B (from dataB q1..q4).
REQ-007 in_valid  input  1  a/b beat present this cycle.
REQ-008 in_last  input  1  beat is final beat of current dot product; qualified by in_valid.
REQ-009 beats  input  8  expected beat count of current dot product, sampled on first beat; 0 disables checking.
REQ-010 result  output  DATA_W  saturated dot product.
REQ-011 ovf  output  1  result was saturated.
REQ-012 out_valid  output  1  one-cycle pulse, result/ovf valid.
REQ-013 err  output  1  one-cycle pulse, beat-count mismatch on the dot product just completed.
REQ-014 busy  output  1  a dot product is open (first beat accepted, last not yet accepted).

Function
REQ-015 Operands unsigned; each product 2*DATA_W bits; four-product sum 2*DATA_W+2 bits; no precision lost before accumulator.
REQ-016 Pipeline of three registered stages: S1 registers four products; S2 registers their sum; S3 accumulates.
REQ-017 first/last flags travel down the pipeline alongside each beat.
REQ-018 S3: first beat loads acc <= sum; later beats acc <= acc + sum; acc wraps modulo 2^ACC_W (no checking beyond ACC_W).
REQ-019 Beat with in_last sampled at edge t: out_valid high during cycle t+3, result = min(final acc, 2^DATA_W-1), ovf = (final acc > 2^DATA_W-1).
REQ-020 result and ovf hold last value between pulses; out_valid low otherwise.
REQ-021 Input FSM: IDLE (no open dot product) and ACC (open); IDLE->ACC on in_valid & !in_last; ACC->IDLE on in_valid & in_last; IDLE stays IDLE on single-beat in_valid & in_last; busy = (state==ACC).
REQ-022 Beat counter: 1 on first beat, +1 per accepted beat, 8-bit, saturates at 255.
REQ-023 err pulses with out_valid when beats!=0 and counter at last beat != beats; result still produced.
REQ-024 Back-to-back dot products: in_valid & in_last at t followed by in_valid at t+1 is legal; new beat is a first beat; no bubble, no cross-contamination.
REQ-025 in_valid low cycles inside a dot product are legal stalls; acc unaffected.
REQ-026 in_last without in_valid is ignored.
REQ-027 No backpressure: block accepts one beat every cycle; consumer must take each out_valid pulse.

Reset
REQ-028 On rst sampled high: state=IDLE, counter=0, all pipeline valid/flag bits=0, acc=0, result=0, ovf=0, out_valid=0, err=0, busy=0.
REQ-029 rst mid-operation discards open dot product and all in-flight beats; no out_valid for them.
REQ-030 Beat presented in the same cycle rst is high is dropped.

Structure
REQ-031 DATA_W/ACC_W defaults and the saturate-to-DATA_W helper live in shared package mm_pkg.
REQ-032 One sub-module dp_sum4: four multipliers plus adder tree covering S1 and S2; top holds FSM, counter, S3, output regs.

Verification
REQ-033 Single beat a=1,2,3,4 b=5,6,7,8 in_last, beats=1 at t -> out_valid at t+3, result=70, ovf=0, err=0.
REQ-034 Two beats (1,2,3,4)x(5,6,7,8) then (1,1,1,1)x(2,2,2,2) last, beats=2, with one idle cycle between -> result=78, busy high from first to last beat.
REQ-035 Single beat all 0xFFFF, beats=1 -> result=0xFFFF, ovf=1.
REQ-036 Back-to-back single-beat dot products (1,0,0,0)x(3,0,0,0) then (2,0,0,0)x(4,0,0,0) -> pulses on consecutive cycles, results 3 then 8.
REQ-037 beats=3 but in_last on beat 2 -> result produced, err=1; repeat with beats=0 -> err=0.
REQ-038 rst asserted after 1 of 2 beats, then fresh single beat (1,1,1,1)x(1,1,1,1) -> no pulse for aborted dot product, result=4.
